// File: rtl/bridge_tx_sched.sv
// -----------------------------------------------------------------------------
// bridge_tx_sched
// Sequences the I2C-to-UART bridge datapath. It pops one byte at a time from
// the receive FIFO and hands it to uart_tx. It also inserts a programmable
// idle gap after every completed byte. Optionally it appends an end-of-line
// byte once per I2C STOP, after the FIFO has drained. A watchdog supervises
// each transmission.
//
// Ports
//   i_clk          system clock, all logic on rising edge
//   i_rst_n        asynchronous active-low reset
//   i_enable       1: scheduling allowed; 0: finish byte in flight, then idle
//   i_fifo_empty   FIFO empty flag
//   i_fifo_rdata   FIFO read data, valid the cycle after o_fifo_rd_en
//   o_fifo_rd_en   one-cycle FIFO pop strobe
//   i_i2c_stop     one-cycle pulse on I2C STOP condition
//   i_tx_active    uart_tx busy
//   i_tx_done      uart_tx one-cycle completion pulse
//   o_tx_dv        one-cycle data-valid strobe to uart_tx
//   o_tx_byte      byte to transmit, stable from o_tx_dv until i_tx_done
//   o_bytes_sent   completed bytes (data + EOL), wraps at 16 bits
//   o_tx_timeout   sticky watchdog error, cleared only by reset
// -----------------------------------------------------------------------------
module bridge_tx_sched #(
  parameter int         GAP_CYCLES = 16,
  parameter bit         EOL_EN     = 1'b1,
  parameter logic [7:0] EOL_BYTE   = 8'h0A,
  parameter int         TIMEOUT    = 100000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_enable,
  input  logic        i_fifo_empty,
  input  logic [7:0]  i_fifo_rdata,
  output logic        o_fifo_rd_en,
  input  logic        i_i2c_stop,
  input  logic        i_tx_active,
  input  logic        i_tx_done,
  output logic        o_tx_dv,
  output logic [7:0]  o_tx_byte,
  output logic [15:0] o_bytes_sent,
  output logic        o_tx_timeout
);

  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam int WW = $clog2(TIMEOUT + 1);
  // Terminal counts. With GAP_CYCLES=0 the gap state is never entered, so the
  // wrapped value of GAP_LAST is harmless.
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
  localparam logic [WW-1:0] WD_LAST  = WW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_POP,
    S_LATCH,
    S_SEND,
    S_WAIT_DONE,
    S_GAP
  } state_t;

  state_t         r_state;
  logic           r_fifo_rd_en;
  logic           r_tx_dv;
  logic [7:0]     r_tx_byte;
  logic [15:0]    r_bytes_sent;
  logic           r_tx_timeout;
  logic           r_eol_pend;
  logic [GW-1:0]  r_gap_cnt;
  logic [WW-1:0]  r_wd_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_fifo_rd_en <= 1'b0;
      r_tx_dv      <= 1'b0;
      r_tx_byte    <= 8'h00;
      r_bytes_sent <= 16'h0000;
      r_tx_timeout <= 1'b0;
      r_eol_pend   <= 1'b0;
      r_gap_cnt    <= '0;
      r_wd_cnt     <= '0;
    end else begin
      // Strobes default low so each is exactly one cycle wide.
      r_fifo_rd_en <= 1'b0;
      r_tx_dv      <= 1'b0;

      case (r_state)
        S_IDLE: begin
          // Pending data always wins over a pending EOL.
          if (i_enable && !i_fifo_empty) begin
            r_fifo_rd_en <= 1'b1;
            r_state      <= S_POP;
          end else if (i_enable && r_eol_pend && i_fifo_empty) begin
            r_tx_byte  <= EOL_BYTE;
            r_eol_pend <= 1'b0;
            r_state    <= S_SEND;
          end
        end

        S_POP: begin
          r_state <= S_LATCH;
        end

        S_LATCH: begin
          r_tx_byte <= i_fifo_rdata;
          r_state   <= S_SEND;
        end

        S_SEND: begin
          if (!i_tx_active) begin
            r_tx_dv  <= 1'b1;
            r_wd_cnt <= '0;
            r_state  <= S_WAIT_DONE;
          end
        end

        S_WAIT_DONE: begin
          if (i_tx_done) begin
            r_bytes_sent <= r_bytes_sent + 16'd1;
            r_gap_cnt    <= '0;
            r_state      <= (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
          end else if (r_wd_cnt == WD_LAST) begin
            r_tx_timeout <= 1'b1;
            r_state      <= S_IDLE;
          end else begin
            r_wd_cnt <= r_wd_cnt + 1'b1;
          end
        end

        S_GAP: begin
          // The gap always runs to completion; enable is only looked at in IDLE.
          if (r_gap_cnt == GAP_LAST) begin
            r_state <= S_IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt + 1'b1;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase

      // Placed after the case so a STOP in the same cycle as an EOL launch
      // re-arms the flag and a second EOL follows.
      if (EOL_EN && i_i2c_stop) begin
        r_eol_pend <= 1'b1;
      end
    end
  end

  assign o_fifo_rd_en = r_fifo_rd_en;
  assign o_tx_dv      = r_tx_dv;
  assign o_tx_byte    = r_tx_byte;
  assign o_bytes_sent = r_bytes_sent;
  assign o_tx_timeout = r_tx_timeout;

endmodule

// File: tb/tb_bridge_tx_sched.sv
// -----------------------------------------------------------------------------
// tb_bridge_tx_sched
// Self-checking bench for bridge_tx_sched.
// The bench models the FIFO and the UART transmitter behaviourally. It keeps
// the expected outgoing byte stream as a queue, filled in push order plus the
// EOL bytes that the STOP rules imply. A second instance, built with EOL
// disabled, sees the same enable and STOP stimulus.
// -----------------------------------------------------------------------------
module tb_bridge_tx_sched;
  localparam int GAP = 16;
  localparam int TMO = 40;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        enable;
  logic        i2c_stop;
  logic        force_active;
  logic        hang_done;

  // FIFO model
  logic [7:0]  mem [0:255];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  logic        fifo_empty;
  logic [7:0]  fifo_rdata = 8'h00;

  // UART model
  logic        u_busy;
  int          u_cnt;
  logic        tx_done;
  logic        tx_active;

  // DUT outputs
  logic        fifo_rd_en;
  logic        tx_dv;
  logic [7:0]  tx_byte;
  logic [15:0] bytes_sent;
  logic        tx_timeout;

  // EOL-disabled instance outputs
  logic        rd2;
  logic        dv2;
  logic [7:0]  byte2;
  logic [15:0] sent2;
  logic        to2;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign tx_active  = u_busy | force_active;

  bridge_tx_sched #(
    .GAP_CYCLES(GAP), .EOL_EN(1'b1), .EOL_BYTE(8'h0A), .TIMEOUT(TMO)
  ) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable),
    .i_fifo_empty(fifo_empty), .i_fifo_rdata(fifo_rdata), .o_fifo_rd_en(fifo_rd_en),
    .i_i2c_stop(i2c_stop), .i_tx_active(tx_active), .i_tx_done(tx_done),
    .o_tx_dv(tx_dv), .o_tx_byte(tx_byte), .o_bytes_sent(bytes_sent),
    .o_tx_timeout(tx_timeout)
  );

  bridge_tx_sched #(
    .GAP_CYCLES(0), .EOL_EN(1'b0), .EOL_BYTE(8'h0A), .TIMEOUT(TMO)
  ) u_dut_noeol (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable),
    .i_fifo_empty(1'b1), .i_fifo_rdata(8'h00), .o_fifo_rd_en(rd2),
    .i_i2c_stop(i2c_stop), .i_tx_active(1'b0), .i_tx_done(1'b0),
    .o_tx_dv(dv2), .o_tx_byte(byte2), .o_bytes_sent(sent2),
    .o_tx_timeout(to2)
  );

  // FIFO pop: data appears the cycle after the read strobe.
  always @(posedge clk) begin
    if (fifo_rd_en) begin
      fifo_rdata <= mem[rd_ptr % 256];
      rd_ptr     <= rd_ptr + 1;
    end
  end

  // UART: accepts a byte on tx_dv, stays busy a random frame time, then
  // pulses tx_done (unless hang_done stalls it).
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      u_busy  <= 1'b0;
      u_cnt   <= 0;
      tx_done <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      if (u_busy) begin
        if (u_cnt == 0) begin
          if (!hang_done) begin
            tx_done <= 1'b1;
            u_busy  <= 1'b0;
          end
        end else begin
          u_cnt <= u_cnt - 1;
        end
      end else if (tx_dv) begin
        u_busy <= 1'b1;
        u_cnt  <= int'($urandom_range(2, 9));
      end
    end
  end

  // Monitor: records every launched byte together with its context.
  int         n_dv   = 0;
  int         n_rd   = 0;
  int         n_dv2  = 0;
  int         n_rd2  = 0;
  int         rd_bad = 0;
  int         since  = 1000;
  logic       prev_dv = 1'b0;
  logic [7:0] sent_q [$];
  int         dv_since [$];
  logic       dv_act [$];
  logic       dv_prev [$];

  always @(negedge clk) begin
    if (!rst_n) begin
      since   = 1000;
      prev_dv = 1'b0;
    end else begin
      if (tx_dv) begin
        n_dv++;
        sent_q.push_back(tx_byte);
        dv_since.push_back(since);
        dv_act.push_back(tx_active);
        dv_prev.push_back(prev_dv);
      end
      if (fifo_rd_en) begin
        n_rd++;
        if (fifo_empty) rd_bad++;
      end
      if (dv2) n_dv2++;
      if (rd2) n_rd2++;
      if (tx_done) since = 0;
      else if (since < 1000) since++;
      prev_dv = tx_dv;
    end
  end

  // Reference model state and bookkeeping
  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] exp_q [$];
  int         exp_bytes = 0;
  int         chk_idx = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic push_raw(input logic [7:0] b);
    mem[wr_ptr % 256] = b;
    wr_ptr++;
  endtask

  task automatic push(input logic [7:0] b);
    push_raw(b);
    exp_q.push_back(b);
  endtask

  task automatic pulse_stop();
    @(negedge clk);
    i2c_stop = 1'b1;
    @(negedge clk);
    i2c_stop = 1'b0;
    #1;
  endtask

  task automatic wait_dv(input int target, input string tag);
    int c;
    c = 0;
    while (n_dv < target && c < 2000) begin
      @(negedge clk);
      #1;
      c++;
    end
    check({tag, "_wait_dv"}, n_dv, target);
  endtask

  task automatic verify(input string tag);
    check({tag, "_count"}, sent_q.size(), exp_q.size());
    for (int i = chk_idx; i < exp_q.size() && i < sent_q.size(); i++) begin
      $display("[%s] byte %0d sent=%02h exp=%02h gap=%0d", tag, i, sent_q[i], exp_q[i], dv_since[i]);
      check({tag, "_byte"}, sent_q[i], exp_q[i]);
      check({tag, "_gap"}, (dv_since[i] > GAP) ? 1 : 0, 1);
      check({tag, "_dv_while_active"}, dv_act[i], 0);
      check({tag, "_dv_one_cycle"}, dv_prev[i], 0);
    end
    chk_idx = sent_q.size();
    check({tag, "_bytes_sent"}, bytes_sent, exp_bytes);
  endtask

  initial begin
    int base_dv;
    int base_rd;
    int k;
    int c;
    logic [15:0] snap;

    rst_n        = 1'b0;
    enable       = 1'b0;
    i2c_stop     = 1'b0;
    force_active = 1'b0;
    hang_done    = 1'b0;
    cyc(3);

    // Reset state
    check("rst_rd_en", fifo_rd_en, 0);
    check("rst_tx_dv", tx_dv, 0);
    check("rst_tx_byte", tx_byte, 8'h00);
    check("rst_bytes_sent", bytes_sent, 0);
    check("rst_timeout", tx_timeout, 0);
    rst_n = 1'b1;
    cyc(2);

    // Three data bytes with the inter-byte gap
    base_dv = n_dv;
    base_rd = n_rd;
    push(8'h11); push(8'h22); push(8'h33);
    enable = 1'b1;
    wait_dv(base_dv + 3, "seq3");
    cyc(40);
    exp_bytes += 3;
    verify("seq3");
    check("seq3_rd_pulses", n_rd, base_rd + 3);

    // STOP in the middle of a stream: EOL after the FIFO drains
    base_dv = n_dv;
    push(8'hA5); push(8'h5A);
    wait_dv(base_dv + 1, "stop_mid");
    pulse_stop();
    exp_q.push_back(8'h0A);
    wait_dv(base_dv + 3, "stop_mid");
    cyc(60);
    exp_bytes += 3;
    verify("stop_mid");
    check("stop_mid_no_extra", n_dv, base_dv + 3);

    // Two STOPs with empty FIFO collapse into one EOL
    base_dv = n_dv;
    enable = 1'b0;
    cyc(2);
    pulse_stop();
    cyc(2);
    pulse_stop();
    cyc(2);
    enable = 1'b1;
    exp_q.push_back(8'h0A);
    wait_dv(base_dv + 1, "two_stop");
    cyc(60);
    exp_bytes += 1;
    verify("two_stop");
    check("two_stop_single_eol", n_dv, base_dv + 1);

    // Randomized bursts, some bytes arriving while transmission is ongoing
    for (int r = 0; r < 6; r++) begin
      base_dv = n_dv;
      base_rd = n_rd;
      k = int'($urandom_range(1, 5));
      for (int j = 0; j < k; j++) begin
        push(8'($urandom_range(0, 255)));
        if ($urandom_range(0, 1) == 1) cyc(int'($urandom_range(1, 30)));
      end
      wait_dv(base_dv + k, "rand");
      cyc(40);
      exp_bytes += k;
      verify("rand");
      check("rand_rd_pulses", n_rd, base_rd + k);
    end

    // tx_active held high on SEND entry
    base_dv = n_dv;
    base_rd = n_rd;
    force_active = 1'b1;
    push(8'h3C);
    cyc(30);
    check("hold_no_dv", n_dv, base_dv);
    check("hold_popped", n_rd, base_rd + 1);
    force_active = 1'b0;
    wait_dv(base_dv + 1, "hold");
    cyc(40);
    exp_bytes += 1;
    verify("hold");
    check("hold_single_dv", n_dv, base_dv + 1);

    // enable dropped during WAIT_DONE: current byte completes, no more pops
    base_dv = n_dv;
    base_rd = n_rd;
    push(8'hC1); push(8'hC2); push(8'hC3);
    wait_dv(base_dv + 1, "en_off");
    enable = 1'b0;
    cyc(80);
    check("en_off_dv", n_dv, base_dv + 1);
    check("en_off_rd", n_rd, base_rd + 1);
    check("en_off_bytes_sent", bytes_sent, 16'(exp_bytes + 1));
    enable = 1'b1;
    wait_dv(base_dv + 3, "en_on");
    cyc(40);
    exp_bytes += 3;
    verify("en_on");

    // Watchdog: tx_done withheld
    hang_done = 1'b1;
    snap = bytes_sent;
    push(8'h77);
    c = 0;
    while (!tx_dv && c < 500) begin
      @(negedge clk);
      c++;
    end
    check("tmo_dv_seen", tx_dv, 1);
    c = 0;
    while (!tx_timeout && c < 500) begin
      @(negedge clk);
      c++;
    end
    check("tmo_cycles", c, TMO);
    check("tmo_flag", tx_timeout, 1);
    check("tmo_bytes_unchanged", bytes_sent, snap);
    // Late tx_done arrives while the scheduler is already idle: ignored.
    hang_done = 1'b0;
    cyc(40);
    check("tmo_late_done_ignored", bytes_sent, snap);
    base_dv = n_dv;
    push(8'h88);
    wait_dv(base_dv + 1, "after_tmo");
    cyc(40);
    exp_bytes += 1;
    verify("after_tmo");
    check("tmo_sticky", tx_timeout, 1);

    // Reset in SEND with a pending EOL
    base_rd = n_rd;
    force_active = 1'b1;
    push_raw(8'h99);
    pulse_stop();
    c = 0;
    while (n_rd == base_rd && c < 200) begin
      cyc(1);
      c++;
    end
    cyc(4);
    rst_n = 1'b0;
    #1;
    check("mid_rst_tx_byte", tx_byte, 8'h00);
    check("mid_rst_bytes_sent", bytes_sent, 0);
    check("mid_rst_timeout", tx_timeout, 0);
    check("mid_rst_tx_dv", tx_dv, 0);
    check("mid_rst_rd_en", fifo_rd_en, 0);
    cyc(2);
    rst_n = 1'b1;
    force_active = 1'b0;
    exp_bytes = 0;
    base_dv = n_dv;
    cyc(80);
    check("mid_rst_no_eol", n_dv, base_dv);
    push(8'($urandom_range(0, 255)));
    push(8'($urandom_range(0, 255)));
    wait_dv(base_dv + 2, "post_rst");
    cyc(40);
    exp_bytes += 2;
    verify("post_rst");

    // Global invariants
    check("no_underflow", rd_bad, 0);
    check("noeol_dv", n_dv2, 0);
    check("noeol_rd", n_rd2, 0);
    check("noeol_sent", sent2, 0);
    check("noeol_timeout", to2, 0);
    check("noeol_byte", byte2, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
